// File: rtl/dmem_subword_ctrl.sv
// Byte/half/word data memory with sign/zero-extended loads, lane-masked stores and a
// req/ready/done handshake. Optional misalignment trapping: DMEM_MISALIGN_TRAP_EN.
module dmem_subword_ctrl #(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int              AW        = ADDR_W + 2;
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           sign_ext_q, sign_ext_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              in_range;
    logic              misalign;
    logic              access_err;
    logic              commit;
    logic              mem_we;
    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic [31:0]       rd_word;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       load_val;

    // Address bits above the word index are architecturally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, addr[31:AW]};

    // ---------------- access decode (on latched request) ----------------
    always_comb begin
        idx      = addr_q[AW-1:2];
        in_range = ({1'b0, idx} < DEPTH_LIM);
        rd_idx   = in_range ? idx : '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((size_q == SZ_HALF) && addr_q[0]) ||
                   ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        access_err = (size_q == SZ_RSVD) || !in_range || misalign;
    end

    // Lane selection; with trapping off, low bits below the access size are simply dropped.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        rd_word = mem[rd_idx];
        case (addr_q[1:0])
            2'd0:    byte_val = rd_word[7:0];
            2'd1:    byte_val = rd_word[15:8];
            2'd2:    byte_val = rd_word[23:16];
            default: byte_val = rd_word[31:24];
        endcase
        half_val = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sign_ext_q & byte_val[7]}}, byte_val};
            SZ_HALF: load_val = {{16{sign_ext_q & half_val[15]}}, half_val};
            default: load_val = rd_word;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                err_d = 1'b0;
                if (req) begin
                    we_d       = we;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    addr_d     = addr[AW-1:0];
                    wdata_d    = wdata;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Stores never touch rdata; any errored load returns zero.
        if (commit) begin
            err_d = access_err;
            if (!we_q) begin
                rdata_d = access_err ? 32'h0 : load_val;
            end
        end
    end

    // The write is suppressed by rst so a reset in WAIT drops the access entirely.
    assign mem_we = commit && we_q && !access_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the request payload and the array are intentionally not reset; they are
    // only consumed after a fresh accept, and resetting the array would cost a clear engine.
    always_ff @(posedge clk) begin
        we_q       <= we_d;
        size_q     <= size_d;
        sign_ext_q <= sign_ext_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule
